// File: rtl/ddr_avmm_width_adapter.sv
// Wide-to-narrow Avalon-MM adapter: serialises writes, scales read bursts and reassembles read data.
// Optional error tracking and command checks are enabled by DDR_AVMM_WIDTH_ADAPTER_ERR_EN.
module ddr_avmm_width_adapter #(
    parameter int S_ADDR_WIDTH       = 27,
    parameter int S_DATA_WIDTH       = 1024,
    parameter int S_BURSTCOUNT_WIDTH = 7,
    parameter int RATIO              = 2,
    parameter int MAX_PENDING        = 64,
    localparam int M_DATA_WIDTH       = S_DATA_WIDTH / RATIO,
    localparam int LR                 = $clog2(RATIO),
    localparam int M_ADDR_WIDTH       = S_ADDR_WIDTH + LR,
    localparam int M_BURSTCOUNT_WIDTH = S_BURSTCOUNT_WIDTH + LR,
    localparam int S_BE_WIDTH         = S_DATA_WIDTH / 8,
    localparam int M_BE_WIDTH         = M_DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [S_ADDR_WIDTH-1:0]       s0_address,
    input  logic                          s0_write,
    input  logic                          s0_read,
    input  logic [S_BURSTCOUNT_WIDTH-1:0] s0_burstcount,
    input  logic [S_DATA_WIDTH-1:0]       s0_writedata,
    input  logic [S_BE_WIDTH-1:0]         s0_byteenable,
    output logic                          s0_waitrequest,
    output logic                          s0_readdatavalid,
    output logic [S_DATA_WIDTH-1:0]       s0_readdata,
    output logic [M_ADDR_WIDTH-1:0]       m0_address,
    output logic                          m0_write,
    output logic                          m0_read,
    output logic [M_BURSTCOUNT_WIDTH-1:0] m0_burstcount,
    output logic [M_DATA_WIDTH-1:0]       m0_writedata,
    output logic [M_BE_WIDTH-1:0]         m0_byteenable,
    input  logic                          m0_waitrequest,
    input  logic                          m0_readdatavalid,
    input  logic [M_DATA_WIDTH-1:0]       m0_readdata,
    output logic [1:0]                    err_status
);

    localparam int IW = (LR > 0) ? LR : 1;
    localparam int PW = $clog2(MAX_PENDING + 1);

    typedef enum logic {IDLE, WR_BURST} state_t;

    state_t                               state_q, state_d;
    logic [IW-1:0]                        sub_idx_q, rd_idx_q;
    logic [S_BURSTCOUNT_WIDTH-1:0]        wr_left_q, wr_left_d;
    logic [M_ADDR_WIDTH-1:0]              wr_addr_q, s_addr_w;
    logic [M_BURSTCOUNT_WIDTH-1:0]        wr_bc_q, s_bc_w;
    logic [PW-1:0]                        pending_q;
    logic [RATIO-1:0][M_DATA_WIDTH-1:0]   wr_lanes, asm_q, asm_d;
    logic [RATIO-1:0][M_BE_WIDTH-1:0]     be_lanes;
    logic                                 wr_fire, wr_last, rd_accept, rd_fire, rd_last, credit_ok;
    logic [31:0]                          credit_sum;

    // Lane 0 is the low slice, so a plain reshape gives the serialisation order.
    assign wr_lanes   = s0_writedata;
    assign be_lanes   = s0_byteenable;
    assign s_addr_w   = M_ADDR_WIDTH'(s0_address) << LR;
    assign s_bc_w     = M_BURSTCOUNT_WIDTH'(s0_burstcount) << LR;
    assign wr_last    = (sub_idx_q == IW'(RATIO - 1));
    assign rd_last    = (rd_idx_q == IW'(RATIO - 1));
    assign credit_sum = 32'(pending_q) + 32'(s0_burstcount);
    assign credit_ok  = (credit_sum <= 32'(MAX_PENDING));
    assign rd_fire    = m0_readdatavalid && (pending_q != '0);

    always_comb begin
        state_d        = state_q;
        wr_left_d      = wr_left_q;
        wr_fire        = 1'b0;
        rd_accept      = 1'b0;
        m0_write       = 1'b0;
        m0_read        = 1'b0;
        m0_address     = s_addr_w;
        m0_burstcount  = s_bc_w;
        m0_writedata   = wr_lanes[sub_idx_q];
        m0_byteenable  = be_lanes[sub_idx_q];
        s0_waitrequest = 1'b1;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (s0_write) begin
                        m0_write       = 1'b1;
                        wr_fire        = !m0_waitrequest;
                        s0_waitrequest = !(wr_fire && wr_last);
                        if (wr_fire) begin
                            wr_left_d = wr_last ? s0_burstcount - 1'b1 : s0_burstcount;
                            if (!(wr_last && s0_burstcount == S_BURSTCOUNT_WIDTH'(1)))
                                state_d = WR_BURST;
                        end
                    end else if (s0_read) begin
                        m0_read        = credit_ok;
                        s0_waitrequest = m0_waitrequest | !credit_ok;
                        rd_accept      = credit_ok && !m0_waitrequest;
                    end
                end
                WR_BURST: begin
                    m0_write       = 1'b1;
                    m0_address     = wr_addr_q;
                    m0_burstcount  = wr_bc_q;
                    wr_fire        = !m0_waitrequest;
                    s0_waitrequest = !(wr_fire && wr_last);
                    if (wr_fire && wr_last) begin
                        wr_left_d = wr_left_q - 1'b1;
                        if (wr_left_q == S_BURSTCOUNT_WIDTH'(1))
                            state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        asm_d = asm_q;
        if (rd_fire)
            asm_d[rd_idx_q] = m0_readdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            sub_idx_q        <= '0;
            rd_idx_q         <= '0;
            wr_left_q        <= '0;
            wr_addr_q        <= '0;
            wr_bc_q          <= '0;
            pending_q        <= '0;
            asm_q            <= '0;
            s0_readdata      <= '0;
            s0_readdatavalid <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_left_q <= wr_left_d;
            if (wr_fire)
                sub_idx_q <= wr_last ? '0 : sub_idx_q + 1'b1;
            if (wr_fire && state_q == IDLE) begin
                wr_addr_q <= s_addr_w;
                wr_bc_q   <= s_bc_w;
            end
            s0_readdatavalid <= rd_fire && rd_last;
            if (rd_fire) begin
                asm_q    <= asm_d;
                rd_idx_q <= rd_last ? '0 : rd_idx_q + 1'b1;
            end
            if (rd_fire && rd_last)
                s0_readdata <= asm_d;
            // Decrement only happens with pending nonzero, so the counter saturates at 0.
            pending_q <= pending_q + (rd_accept ? PW'(s0_burstcount) : PW'(0))
                                   - PW'(rd_fire && rd_last);
        end
    end

`ifdef DDR_AVMM_WIDTH_ADAPTER_ERR_EN
    logic [1:0] err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 2'b00;
        end else begin
            if (m0_readdatavalid && pending_q == '0)
                err_q[0] <= 1'b1;
            // A dropped beat that would have closed a wide word is a decrement with nothing owed.
            if (m0_readdatavalid && rd_last && pending_q == '0)
                err_q[1] <= 1'b1;
        end
    end

    assign err_status = err_q;

    always_ff @(posedge clk) begin
        if (!reset && ((wr_fire && state_q == IDLE) || rd_accept))
            assert (s0_burstcount != '0);
    end
`else
    assign err_status = 2'b00;
`endif

endmodule
